// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement operands when SEQ_DIV_SIGNED_EN is defined.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [WIDTH-1:0] r_dsr, w_dsr_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
    logic             w_busy_nxt, w_done_nxt, w_dbz_nxt;
    logic [WIDTH-1:0] w_q_out_nxt, w_r_out_nxt;

    // One restoring step on the working registers
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_step, w_quo_step;

    assign w_trial    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_trial >= {1'b0, r_dsr});
    assign w_rem_step = w_ge ? (w_trial[WIDTH-1:0] - r_dsr) : w_trial[WIDTH-1:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

    // Operand magnitudes and result signs
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

`ifdef SEQ_DIV_SIGNED_EN
    assign w_a_neg = dividend[WIDTH-1];
    assign w_b_neg = divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? (WIDTH'(0) - dividend) : dividend;
    assign w_b_mag = w_b_neg ? (WIDTH'(0) - divisor) : divisor;
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
    assign w_a_mag = dividend;
    assign w_b_mag = divisor;
`endif

    logic [WIDTH-1:0] w_q_fin, w_r_fin;
    assign w_q_fin = r_neg_q ? (WIDTH'(0) - w_quo_step) : w_quo_step;
    assign w_r_fin = r_neg_r ? (WIDTH'(0) - w_rem_step) : w_rem_step;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_dsr_nxt   = r_dsr;
        w_cnt_nxt   = r_cnt;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_q_out_nxt = quotient;
        w_r_out_nxt = remainder;
        w_dbz_nxt   = div_by_zero;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_rem_nxt   = '0;
                    w_quo_nxt   = w_a_mag;
                    w_dsr_nxt   = w_b_mag;
                    w_neg_q_nxt = w_a_neg ^ w_b_neg;
                    w_neg_r_nxt = w_a_neg;
                    if (divisor == '0) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                        w_q_out_nxt = '1;
                        w_r_out_nxt = dividend;
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = CW'(WIDTH);
                    end
                end else if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_rem_nxt = w_rem_step;
                w_quo_nxt = w_quo_step;
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                    w_q_out_nxt = w_q_fin;
                    w_r_out_nxt = w_r_fin;
                    w_dbz_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == S_RUN);
        // done trails the DONE state by one cycle so results are settled when it pulses
        w_done_nxt = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_dsr       <= w_dsr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_neg_q     <= w_neg_q_nxt;
            r_neg_r     <= w_neg_r_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            quotient    <= w_q_out_nxt;
            remainder   <= w_r_out_nxt;
            div_by_zero <= w_dbz_nxt;
        end
    end

endmodule
